// File: rtl/filter_window_ctrl.sv
// Sequencing controller for a FILTER_SIZE x FILTER_SIZE windowed image filter.
// Fetches raster pixels, drives line-buffer strobes and emits zero-padded window descriptors.
module filter_window_ctrl #(
    parameter int IMG_W       = 225,
    parameter int IMG_H       = 225,
    parameter int FILTER_SIZE = 3,
    parameter int CW          = 12
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_vsync,
    input  logic          i_src_valid,
    output logic          o_src_next,
    output logic          o_lb_wr_en,
    output logic [CW-1:0] o_lb_wr_addr,
    output logic          o_lb_shift,
    output logic          o_win_valid,
    input  logic          i_sink_ready,
    output logic [CW-1:0] o_win_x,
    output logic [CW-1:0] o_win_y,
    output logic [3:0]    o_border,
    output logic          o_frame_done,
    output logic          o_busy
);
    localparam int PAD = FILTER_SIZE / 2;
    localparam logic [CW-1:0] PAD_C  = CW'(PAD);
    localparam logic [CW-1:0] W_C    = CW'(IMG_W);
    localparam logic [CW-1:0] H_C    = CW'(IMG_H);
    localparam logic [CW-1:0] W_LAST = CW'(IMG_W - 1);
    localparam logic [CW-1:0] RF_X0  = CW'(IMG_W - PAD);
    localparam logic [CW-1:0] FF_Y0  = CW'(IMG_H - PAD);

    // state        | meaning
    // S_IDLE       | waiting for a vsync falling edge
    // S_FILL       | fetching pixels, windows emitted PAD pixels behind the fetch
    // S_ROW_FLUSH  | emitting the right-hand padded windows of the current row
    // S_FRAME_FLUSH| emitting the bottom padded rows, no fetch
    // S_DONE       | one-cycle frame-done pulse
    typedef enum logic [2:0] {
        S_IDLE, S_FILL, S_ROW_FLUSH, S_FRAME_FLUSH, S_DONE
    } state_t;

    state_t        state, state_nxt;
    logic          vs_prev, vs_fall, stall, consume, fill_win;
    logic          flush_state, flush_pend, flush_load, win_load, shift_q;
    logic [CW-1:0] sx, sy, fx, fy, ld_x, ld_y;

    assign vs_fall     = vs_prev & ~i_vsync;
    assign stall       = o_win_valid & ~i_sink_ready;
    assign consume     = o_src_next & i_src_valid;
    assign fill_win    = consume & (sx >= PAD_C) & (sy >= PAD_C);
    assign flush_state = (state == S_ROW_FLUSH) | (state == S_FRAME_FLUSH);
    assign flush_pend  = (state == S_ROW_FLUSH) ? (fx < W_C) : (fy < H_C);
    assign flush_load  = flush_state & flush_pend & ~stall & ~vs_fall;
    assign win_load    = fill_win | flush_load;
    assign o_lb_shift  = shift_q;

    // Row flush keeps the row of the descriptor that was loaded on entry.
    always_comb begin
        ld_x = fx;
        ld_y = fy;
        if (state == S_FILL) begin
            ld_x = sx - PAD_C;
            ld_y = sy - PAD_C;
        end else if (state == S_ROW_FLUSH) begin
            ld_y = o_win_y;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (vs_fall) begin
            state_nxt = S_FILL;
        end else begin
            case (state)
                S_IDLE: state_nxt = S_IDLE;
                S_FILL: begin
                    if (consume && sx == W_LAST && sy >= PAD_C) state_nxt = S_ROW_FLUSH;
                end
                S_ROW_FLUSH: begin
                    if (!flush_pend && !stall) state_nxt = (sy == H_C) ? S_FRAME_FLUSH : S_FILL;
                end
                S_FRAME_FLUSH: begin
                    if (!flush_pend && !stall) state_nxt = S_DONE;
                end
                S_DONE:  state_nxt = S_IDLE;
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    always_comb begin
        o_src_next   = (state == S_FILL) & ~stall & ~vs_fall;
        o_lb_wr_en   = o_src_next & i_src_valid;
        o_lb_wr_addr = sx;
        o_frame_done = (state == S_DONE);
        o_busy       = (state != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vs_prev     <= 1'b1;
            sx          <= '0;
            sy          <= '0;
            fx          <= '0;
            fy          <= '0;
            shift_q     <= 1'b0;
            o_win_valid <= 1'b0;
            o_win_x     <= '0;
            o_win_y     <= '0;
            o_border    <= '0;
        end else begin
            vs_prev <= i_vsync;
            shift_q <= 1'b0;
            if (vs_fall) begin
                sx          <= '0;
                sy          <= '0;
                fx          <= '0;
                fy          <= '0;
                o_win_valid <= 1'b0;
            end else begin
                if (consume) begin
                    if (sx == W_LAST) begin
                        sx <= '0;
                        sy <= sy + 1'b1;
                        if (sy < PAD_C) shift_q <= 1'b1;
                    end else begin
                        sx <= sx + 1'b1;
                    end
                end
                if (flush_load) begin
                    if (state == S_FRAME_FLUSH && fx == W_LAST) begin
                        fx <= '0;
                        fy <= fy + 1'b1;
                    end else begin
                        fx <= fx + 1'b1;
                    end
                    // Starting a new bottom row means the previous one has been accepted.
                    if (state == S_FRAME_FLUSH && fx == '0 && fy != FF_Y0) shift_q <= 1'b1;
                end
                if (state == S_FILL && state_nxt == S_ROW_FLUSH) fx <= RF_X0;
                if (state == S_ROW_FLUSH && state_nxt != S_ROW_FLUSH) begin
                    shift_q <= 1'b1;
                    fx      <= '0;
                    fy      <= FF_Y0;
                end
                if (win_load) begin
                    o_win_valid <= 1'b1;
                    o_win_x     <= ld_x;
                    o_win_y     <= ld_y;
                    o_border    <= {ld_y < PAD_C, ld_y >= FF_Y0, ld_x < PAD_C, ld_x >= RF_X0};
                end else if (o_win_valid && i_sink_ready) begin
                    o_win_valid <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_filter_window_ctrl.sv
// Self-checking bench for filter_window_ctrl on a 5x4 frame with a 3x3 kernel.
module tb_filter_window_ctrl;
    localparam int W = 5, H = 4, FS = 3, CW = 12, PAD = FS / 2;
    localparam int MAX_CYC = 2000;

    logic clk = 1'b0, rst_n = 1'b0, i_vsync = 1'b1, i_src_valid = 1'b0, i_sink_ready = 1'b0;
    logic o_src_next, o_lb_wr_en, o_lb_shift, o_win_valid, o_frame_done, o_busy;
    logic [CW-1:0] o_lb_wr_addr, o_win_x, o_win_y;
    logic [3:0] o_border;

    int checks = 0, failures = 0;

    int addr_q[$];
    int wx_q[$], wy_q[$], wb_q[$];
    int n_shift, n_done, first_win_cyc, kth_cons_cyc, hold_err, stall_err, hs_err, n_stalled;
    int abort_valid, abort_addr, end_busy;
    bit timed_out;

    filter_window_ctrl #(.IMG_W(W), .IMG_H(H), .FILTER_SIZE(FS), .CW(CW)) dut (
        .clk(clk), .rst_n(rst_n), .i_vsync(i_vsync), .i_src_valid(i_src_valid),
        .o_src_next(o_src_next), .o_lb_wr_en(o_lb_wr_en), .o_lb_wr_addr(o_lb_wr_addr),
        .o_lb_shift(o_lb_shift), .o_win_valid(o_win_valid), .i_sink_ready(i_sink_ready),
        .o_win_x(o_win_x), .o_win_y(o_win_y), .o_border(o_border),
        .o_frame_done(o_frame_done), .o_busy(o_busy)
    );

    always #5 clk = ~clk;

    // Reference border flags {top,bottom,left,right} for a window centre.
    function automatic int exp_border(input int x, input int y);
        int b;
        b = 0;
        if (y < PAD)      b += 8;
        if (y >= H - PAD) b += 4;
        if (x < PAD)      b += 2;
        if (x >= W - PAD) b += 1;
        return b;
    endfunction

    // Runs one frame and records what the DUT did; no judgement is made here.
    // src_mode: 0 always, 1 alternating, 2 random. sink_mode: 0 always, 1 random, 2 stall at (2,1).
    task automatic run_frame(input int src_mode, input int sink_mode, input int abort_after);
        int ncons, phase, done_at;
        bit prev_stall;
        logic [CW-1:0] px, py;
        logic [3:0] pb;
        ncons = 0; phase = 0; done_at = -1; prev_stall = 0;
        px = '0; py = '0; pb = '0;
        addr_q.delete(); wx_q.delete(); wy_q.delete(); wb_q.delete();
        n_shift = 0; n_done = 0; first_win_cyc = -1; kth_cons_cyc = -1;
        hold_err = 0; stall_err = 0; hs_err = 0; n_stalled = 0;
        abort_valid = -1; abort_addr = -1; end_busy = -1; timed_out = 1;
        @(negedge clk); i_vsync = 1'b1; i_src_valid = 1'b0; i_sink_ready = 1'b1;
        @(negedge clk); i_vsync = 1'b0;
        for (int cyc = 0; cyc < MAX_CYC; cyc++) begin
            @(negedge clk);
            case (src_mode)
                0: i_src_valid = 1'b1;
                1: i_src_valid = (cyc % 2 == 0);
                default: i_src_valid = 1'($urandom_range(0, 1));
            endcase
            case (sink_mode)
                0: i_sink_ready = 1'b1;
                1: i_sink_ready = ($urandom_range(0, 3) != 0);
                default: begin
                    if (o_win_valid && o_win_x == 2 && o_win_y == 1 && n_stalled < 3) begin
                        i_sink_ready = 1'b0;
                        n_stalled++;
                    end else begin
                        i_sink_ready = 1'b1;
                    end
                end
            endcase
            if (phase == 1) begin
                i_vsync = 1'b1; i_src_valid = 1'b0; phase = 2;
            end else if (phase == 2) begin
                i_vsync = 1'b0; i_src_valid = 1'b0; phase = 3;
            end else if (phase == 3) begin
                addr_q.delete(); wx_q.delete(); wy_q.delete(); wb_q.delete();
                n_shift = 0; ncons = 0; first_win_cyc = -1; kth_cons_cyc = -1;
                prev_stall = 0;
                abort_valid = int'(o_win_valid);
                abort_addr = int'(o_lb_wr_addr);
                phase = 4;
            end
            #1;
            if (prev_stall && (!o_win_valid || o_win_x !== px || o_win_y !== py || o_border !== pb))
                hold_err++;
            if (o_win_valid && !i_sink_ready && (o_src_next || o_lb_wr_en)) stall_err++;
            if (o_lb_wr_en !== (o_src_next & i_src_valid)) hs_err++;
            if (o_lb_wr_en) begin
                addr_q.push_back(int'(o_lb_wr_addr));
                if (ncons == PAD * W + PAD) kth_cons_cyc = cyc;
                ncons++;
            end
            if (o_win_valid && first_win_cyc < 0) first_win_cyc = cyc;
            if (o_win_valid && i_sink_ready) begin
                wx_q.push_back(int'(o_win_x));
                wy_q.push_back(int'(o_win_y));
                wb_q.push_back(int'(o_border));
            end
            if (o_lb_shift) n_shift++;
            if (o_frame_done) begin
                n_done++;
                done_at = cyc;
            end
            prev_stall = o_win_valid && !i_sink_ready;
            px = o_win_x; py = o_win_y; pb = o_border;
            if (phase == 0 && abort_after > 0 && ncons == abort_after) phase = 1;
            if (done_at >= 0 && cyc == done_at + 1) begin
                end_busy = int'(o_busy);
                timed_out = 0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; i_vsync = 1'b1; i_src_valid = 1'b1; i_sink_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if ({o_src_next, o_lb_wr_en, o_lb_wr_addr, o_lb_shift, o_win_valid, o_win_x, o_win_y,
             o_border, o_frame_done, o_busy} !== 46'd0) begin
            failures++;
            $display("FAIL reset_outputs: got %0h required 0", {o_src_next, o_lb_wr_en, o_lb_wr_addr,
                     o_lb_shift, o_win_valid, o_win_x, o_win_y, o_border, o_frame_done, o_busy});
        end
        @(negedge clk); rst_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk); #1;
            checks++;
            if ({o_src_next, o_lb_wr_en, o_lb_wr_addr, o_lb_shift, o_win_valid, o_win_x, o_win_y,
                 o_border, o_frame_done, o_busy} !== 46'd0) begin
                failures++;
                $display("FAIL idle_no_vsync cycle %0d: got %0h required 0", c, {o_src_next, o_lb_wr_en,
                         o_lb_wr_addr, o_lb_shift, o_win_valid, o_win_x, o_win_y, o_border,
                         o_frame_done, o_busy});
            end
        end
    endtask

    task automatic test_basic();
        run_frame(0, 0, -1);
        checks++; if (timed_out !== 1'b0) begin failures++; $display("FAIL basic_timeout: got 1 required 0"); end
        checks++; if (addr_q.size() !== W * H) begin failures++; $display("FAIL basic_consumes: got %0d required %0d", addr_q.size(), W * H); end
        foreach (addr_q[i]) begin
            checks++;
            if (addr_q[i] !== i % W) begin failures++; $display("FAIL basic_addr[%0d]: got %0d required %0d", i, addr_q[i], i % W); end
        end
        checks++; if (wx_q.size() !== W * H) begin failures++; $display("FAIL basic_windows: got %0d required %0d", wx_q.size(), W * H); end
        foreach (wx_q[i]) begin
            checks++;
            if (wx_q[i] !== i % W || wy_q[i] !== i / W || wb_q[i] !== exp_border(i % W, i / W)) begin
                failures++;
                $display("FAIL basic_win[%0d]: got (%0d,%0d,%0h) required (%0d,%0d,%0h)", i, wx_q[i], wy_q[i],
                         wb_q[i], i % W, i / W, exp_border(i % W, i / W));
            end
        end
        checks++; if (first_win_cyc - kth_cons_cyc !== 1) begin failures++; $display("FAIL basic_latency: got %0d required 1", first_win_cyc - kth_cons_cyc); end
        checks++; if (n_shift !== H + PAD - 1) begin failures++; $display("FAIL basic_shifts: got %0d required %0d", n_shift, H + PAD - 1); end
        checks++; if (n_done !== 1) begin failures++; $display("FAIL basic_done: got %0d required 1", n_done); end
        checks++; if (end_busy !== 0) begin failures++; $display("FAIL basic_idle_after: got busy=%0d required 0", end_busy); end
    endtask

    task automatic test_stall();
        run_frame(0, 2, -1);
        checks++; if (timed_out !== 1'b0) begin failures++; $display("FAIL stall_timeout: got 1 required 0"); end
        checks++; if (n_stalled !== 3) begin failures++; $display("FAIL stall_cycles: got %0d required 3", n_stalled); end
        checks++; if (hold_err !== 0) begin failures++; $display("FAIL stall_hold: got %0d unstable cycles required 0", hold_err); end
        checks++; if (stall_err !== 0) begin failures++; $display("FAIL stall_fetch: got %0d fetch cycles required 0", stall_err); end
        checks++; if (wx_q.size() !== W * H) begin failures++; $display("FAIL stall_windows: got %0d required %0d", wx_q.size(), W * H); end
        foreach (wx_q[i]) begin
            checks++;
            if (wx_q[i] !== i % W || wy_q[i] !== i / W) begin
                failures++;
                $display("FAIL stall_win[%0d]: got (%0d,%0d) required (%0d,%0d)", i, wx_q[i], wy_q[i], i % W, i / W);
            end
        end
    endtask

    task automatic test_src_gap();
        run_frame(1, 0, -1);
        checks++; if (timed_out !== 1'b0) begin failures++; $display("FAIL gap_timeout: got 1 required 0"); end
        checks++; if (hs_err !== 0) begin failures++; $display("FAIL gap_wr_en: got %0d bad cycles required 0", hs_err); end
        checks++; if (addr_q.size() !== W * H) begin failures++; $display("FAIL gap_consumes: got %0d required %0d", addr_q.size(), W * H); end
        foreach (addr_q[i]) begin
            checks++;
            if (addr_q[i] !== i % W) begin failures++; $display("FAIL gap_addr[%0d]: got %0d required %0d", i, addr_q[i], i % W); end
        end
        checks++; if (wx_q.size() !== W * H) begin failures++; $display("FAIL gap_windows: got %0d required %0d", wx_q.size(), W * H); end
        foreach (wx_q[i]) begin
            checks++;
            if (wx_q[i] !== i % W || wy_q[i] !== i / W) begin
                failures++;
                $display("FAIL gap_win[%0d]: got (%0d,%0d) required (%0d,%0d)", i, wx_q[i], wy_q[i], i % W, i / W);
            end
        end
    endtask

    task automatic test_abort();
        run_frame(0, 0, 9);
        checks++; if (timed_out !== 1'b0) begin failures++; $display("FAIL abort_timeout: got 1 required 0"); end
        checks++; if (abort_valid !== 0) begin failures++; $display("FAIL abort_valid_drop: got %0d required 0", abort_valid); end
        checks++; if (abort_addr !== 0) begin failures++; $display("FAIL abort_addr_reset: got %0d required 0", abort_addr); end
        checks++; if (n_done !== 1) begin failures++; $display("FAIL abort_done_count: got %0d required 1", n_done); end
        checks++; if (addr_q.size() !== W * H) begin failures++; $display("FAIL abort_consumes: got %0d required %0d", addr_q.size(), W * H); end
        checks++; if (n_shift !== H + PAD - 1) begin failures++; $display("FAIL abort_shifts: got %0d required %0d", n_shift, H + PAD - 1); end
        checks++; if (first_win_cyc - kth_cons_cyc !== 1) begin failures++; $display("FAIL abort_latency: got %0d required 1", first_win_cyc - kth_cons_cyc); end
        checks++; if (wx_q.size() !== W * H) begin failures++; $display("FAIL abort_windows: got %0d required %0d", wx_q.size(), W * H); end
        foreach (wx_q[i]) begin
            checks++;
            if (wx_q[i] !== i % W || wy_q[i] !== i / W) begin
                failures++;
                $display("FAIL abort_win[%0d]: got (%0d,%0d) required (%0d,%0d)", i, wx_q[i], wy_q[i], i % W, i / W);
            end
        end
    endtask

    task automatic test_border();
        run_frame(0, 1, -1);
        checks++; if (wb_q.size() !== W * H) begin failures++; $display("FAIL border_windows: got %0d required %0d", wb_q.size(), W * H); end
        if (wb_q.size() == W * H) begin
            checks++; if (wb_q[0] !== 4'b1010) begin failures++; $display("FAIL border_0_0: got %0h required a", wb_q[0]); end
            checks++; if (wb_q[W * H - 1] !== 4'b0101) begin failures++; $display("FAIL border_4_3: got %0h required 5", wb_q[W * H - 1]); end
            checks++; if (wb_q[W + 2] !== 4'b0000) begin failures++; $display("FAIL border_2_1: got %0h required 0", wb_q[W + 2]); end
        end
    endtask

    task automatic test_random();
        for (int f = 0; f < 4; f++) begin
            run_frame(2, 1, -1);
            checks++; if (timed_out !== 1'b0) begin failures++; $display("FAIL rand%0d_timeout: got 1 required 0", f); end
            checks++; if (hold_err !== 0) begin failures++; $display("FAIL rand%0d_hold: got %0d required 0", f, hold_err); end
            checks++; if (stall_err !== 0) begin failures++; $display("FAIL rand%0d_stall_fetch: got %0d required 0", f, stall_err); end
            checks++; if (hs_err !== 0) begin failures++; $display("FAIL rand%0d_wr_en: got %0d required 0", f, hs_err); end
            checks++; if (n_shift !== H + PAD - 1) begin failures++; $display("FAIL rand%0d_shifts: got %0d required %0d", f, n_shift, H + PAD - 1); end
            checks++; if (n_done !== 1) begin failures++; $display("FAIL rand%0d_done: got %0d required 1", f, n_done); end
            checks++; if (addr_q.size() !== W * H) begin failures++; $display("FAIL rand%0d_consumes: got %0d required %0d", f, addr_q.size(), W * H); end
            foreach (addr_q[i]) begin
                checks++;
                if (addr_q[i] !== i % W) begin failures++; $display("FAIL rand%0d_addr[%0d]: got %0d required %0d", f, i, addr_q[i], i % W); end
            end
            checks++; if (wx_q.size() !== W * H) begin failures++; $display("FAIL rand%0d_windows: got %0d required %0d", f, wx_q.size(), W * H); end
            foreach (wx_q[i]) begin
                checks++;
                if (wx_q[i] !== i % W || wy_q[i] !== i / W || wb_q[i] !== exp_border(i % W, i / W)) begin
                    failures++;
                    $display("FAIL rand%0d_win[%0d]: got (%0d,%0d,%0h) required (%0d,%0d,%0h)", f, i, wx_q[i],
                             wy_q[i], wb_q[i], i % W, i / W, exp_border(i % W, i / W));
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_src_gap();
        test_abort();
        test_border();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
